// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder cell iterated LSB-first over WIDTH bits with valid/ready on both sides.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             fa_sum, fa_cout;
    logic             accept, last_bit;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

    assign accept   = in_valid && in_ready;
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

`ifdef SERIAL_ADDER_SUB_EN
    // a - b == a + ~b + 1; carry-out high means no borrow
    assign b_load = in_sub ? ~in_b : in_b;
    assign c_load = in_sub ? 1'b1 : in_cin;
`else
    logic unused_sub;
    assign unused_sub = in_sub;
    assign b_load     = in_b;
    assign c_load     = in_cin;
`endif

    full_adder u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = RUN;
            RUN:     if (last_bit)  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE:    in_ready = 1'b1;
            RUN:     busy = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    // Sum bits enter at the MSB, so after WIDTH shifts bit 0 holds the first result bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else if (state == IDLE) begin
            if (accept) begin
                a_q     <= in_a;
                b_q     <= b_load;
                carry_q <= c_load;
                cnt_q   <= '0;
            end
        end else if (state == RUN) begin
            a_q     <= a_q >> 1;
            b_q     <= b_q >> 1;
            sum_q   <= {fa_sum, sum_q[WIDTH-1:1]};
            carry_q <= fa_cout;
            cnt_q   <= cnt_q + 1'b1;
        end
    end

    assign out_sum  = sum_q;
    assign out_cout = carry_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8; expected values are hand-computed constants.

module tb_serial_adder_ctrl;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a, in_b;
    logic             in_cin, in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation with out_ready high; check latency, result and return to IDLE.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic sub,
                          input logic [7:0] esum, input logic ecout);
        int n;
        chk({tag, ".in_ready_pre"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_sub = sub;
        tick();
        in_valid = 1'b0;
        chk({tag, ".busy_run"}, 32'(busy), 32'd1);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        chk({tag, ".latency"}, 32'(n), 32'(WIDTH));
        chk({tag, ".sum"}, 32'(out_sum), 32'(esum));
        chk({tag, ".cout"}, 32'(out_cout), 32'(ecout));
        tick();
        chk({tag, ".valid_1cyc"}, 32'(out_valid), 32'd0);
        chk({tag, ".in_ready_post"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] held_sum;
        logic       held_cout;
        logic [7:0] qa [3];
        logic [7:0] qb [3];
        logic [7:0] qs [3];
        logic       qc [3];
        int         n, idx, ridx, cyc, last_acc;
        logic       acc_now;

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
        #12;
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.sum", 32'(out_sum), 32'd0);
        chk("rst.cout", 32'(out_cout), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        tick();

        run_op("add5a3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0);
        run_op("addff01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
        run_op("addff00c", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
        run_op("add0000", 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);

        // Backpressure: hold DONE for 5 cycles while a new operand is offered.
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 8'h21; in_b = 8'h43; in_cin = 1'b1;
        tick();
        in_a = 8'hAA; in_b = 8'h55;
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        chk("bp.latency", 32'(n), 32'(WIDTH));
        held_sum  = 8'h65;
        held_cout = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp.valid", 32'(out_valid), 32'd1);
            chk("bp.sum", 32'(out_sum), 32'(held_sum));
            chk("bp.cout", 32'(out_cout), 32'(held_cout));
            chk("bp.in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp.release_valid", 32'(out_valid), 32'd0);
        chk("bp.release_ready", 32'(in_ready), 32'd1);
        tick();
        chk("bp.no_accept", 32'(busy), 32'd0);

        // Reset in the middle of RUN discards the operation.
        in_valid = 1'b1; in_a = 8'h12; in_b = 8'h34; in_cin = 1'b0;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        chk("mid.busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid.in_ready", 32'(in_ready), 32'd1);
        chk("mid.out_valid", 32'(out_valid), 32'd0);
        chk("mid.sum", 32'(out_sum), 32'd0);
        chk("mid.cout", 32'(out_cout), 32'd0);
        chk("mid.busy", 32'(busy), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < WIDTH + 2; i++) begin
            tick();
            if (out_valid) n++;
        end
        chk("mid.no_emit", 32'(n), 32'd0);
        run_op("after_rst", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0);

        // Back-to-back with in_valid held high: one acceptance per WIDTH+2 cycles, in order.
        qa[0] = 8'h01; qb[0] = 8'h02; qs[0] = 8'h03; qc[0] = 1'b0;
        qa[1] = 8'h80; qb[1] = 8'h80; qs[1] = 8'h00; qc[1] = 1'b1;
        qa[2] = 8'h7F; qb[2] = 8'h01; qs[2] = 8'h80; qc[2] = 1'b0;
        idx = 0; ridx = 0; cyc = 0; last_acc = -1;
        in_valid = 1'b1; in_a = qa[0]; in_b = qb[0]; in_cin = 1'b0;
        while (ridx < 3 && cyc < 80) begin
            acc_now = in_ready && in_valid;
            tick();
            cyc++;
            if (acc_now) begin
                if (last_acc >= 0) chk("b2b.period", 32'(cyc - last_acc), 32'(WIDTH + 2));
                last_acc = cyc;
                idx++;
                if (idx < 3) begin
                    in_a = qa[idx]; in_b = qb[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                chk("b2b.sum", 32'(out_sum), 32'(qs[ridx]));
                chk("b2b.cout", 32'(out_cout), 32'(qc[ridx]));
                ridx++;
            end
        end
        chk("b2b.results", 32'(ridx), 32'd3);
        in_valid = 1'b0;
        tick();

`ifdef SERIAL_ADDER_SUB_EN
        run_op("sub10_01", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
        run_op("sub00_01", 8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0);
        run_op("sub_cin_ign", 8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b1);
`else
        run_op("nosub", 8'h10, 8'h01, 1'b0, 1'b1, 8'h11, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
